// File: rtl/alu_ser_pkg.sv
// Shared definitions for the ALU mantissa serial link.
// Holds the link FSM states, the default mantissa width and the bit-order encodings.
package alu_ser_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } ser_state_t;

   localparam int unsigned MANT_W = 23;

   localparam logic ORDER_LSB_FIRST = 1'b0;
   localparam logic ORDER_MSB_FIRST = 1'b1;

   // Serial frame length: data bits plus an optional trailing parity bit.
   function automatic int unsigned frame_len(input int unsigned width, input bit parity);
      return parity ? width + 1 : width;
   endfunction

endpackage

// File: rtl/mant_deser23_if.sv
// Serial-in / parallel-out handshake bundle of the mantissa deserializer.
// The slave modport is the receiver's view; the master modport is the environment's.
interface mant_deser23_if #(
   parameter int unsigned WIDTH = alu_ser_pkg::MANT_W
);
   logic             s_valid;
   logic             s_bit;
   logic             reverse;
   logic             s_ready;
   logic             m_valid;
   logic [WIDTH-1:0] m_data;
   logic             m_ready;
   logic             m_perr;

   modport slave (
      input  s_valid, s_bit, reverse, m_ready,
      output s_ready, m_valid, m_data, m_perr
   );

   modport master (
      output s_valid, s_bit, reverse, m_ready,
      input  s_ready, m_valid, m_data, m_perr
   );
endinterface

// File: rtl/ser_bit_counter.sv
// Modulo-WIDTH bit counter for the mantissa serial link (shared with the serializer).
// tc flags the last count; an increment at tc wraps back to zero.
module ser_bit_counter
   import alu_ser_pkg::*;
#(
   parameter int unsigned WIDTH = MANT_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     inc,
   output logic [$clog2(WIDTH)-1:0] cnt,
   output logic                     tc
);
   localparam int unsigned CW = $clog2(WIDTH);

   assign tc = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= tc ? '0 : cnt + 1'b1;
      end
   end
endmodule

// File: rtl/mant_deser23.sv
// Bit-serial to parallel mantissa receiver with per-frame LSB/MSB-first ordering.
// Optional trailing even-parity bit enabled by defining DESER_PARITY_EN.
module mant_deser23
   import alu_ser_pkg::*;
#(
   parameter int unsigned WIDTH = MANT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   output logic               busy,
   mant_deser23_if.slave      bus
);
`ifdef DESER_PARITY_EN
   localparam int unsigned FRAME = frame_len(WIDTH, 1'b1);
`else
   localparam int unsigned FRAME = frame_len(WIDTH, 1'b0);
`endif
   localparam int unsigned CW = $clog2(FRAME);

   ser_state_t       state_q, state_d;
   logic             rev_q;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] we;
   logic [CW-1:0]    cnt;
   logic             tc;
   logic             ready;
   logic             accept;
   logic             order;

   assign ready  = (state_q != HOLD);
   assign accept = bus.s_valid && ready;
   // The first bit of a frame uses the live flag; later bits use the latched copy.
   assign order  = (state_q == IDLE) ? bus.reverse : rev_q;

   ser_bit_counter #(.WIDTH(FRAME)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (flush),
      .inc   (accept),
      .cnt   (cnt),
      .tc    (tc)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = SHIFT;
         SHIFT:   if (accept && tc) state_d = HOLD;
         HOLD:    if (bus.m_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   // A parity bit (cnt == WIDTH) matches no data position and is never stored.
   always_comb begin
      we = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (accept && !flush) begin
            if (order == ORDER_MSB_FIRST) we[i] = (cnt == CW'(WIDTH - 1 - i));
            else                          we[i] = (cnt == CW'(i));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rev_q   <= ORDER_LSB_FIRST;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept && !flush && state_q == IDLE) rev_q <= bus.reverse;
         for (int unsigned i = 0; i < WIDTH; i++) begin
            if (we[i]) data_q[i] <= bus.s_bit;
         end
      end
   end

`ifdef DESER_PARITY_EN
   logic par_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_q <= 1'b0;
      end else if (accept && !flush) begin
         par_q <= (state_q == IDLE) ? bus.s_bit : (par_q ^ bus.s_bit);
      end
   end

   assign bus.m_perr = (state_q == HOLD) && par_q;
`else
   assign bus.m_perr = 1'b0;
`endif

   assign bus.s_ready = ready;
   assign bus.m_valid = (state_q == HOLD);
   assign bus.m_data  = data_q;
   assign busy        = (state_q == SHIFT);
endmodule

// File: tb/tb_mant_deser23.sv
// Scoreboard bench for mant_deser23: directed frames queue expected words, a monitor checks them.
// Parity-specific expectations follow DESER_PARITY_EN.
module tb_mant_deser23;
   import alu_ser_pkg::*;

   localparam int unsigned W = MANT_W;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   logic busy;

   mant_deser23_if #(.WIDTH(W)) bus ();

   mant_deser23 #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .busy  (busy),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] data;
      logic         perr;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic exp_perr(input logic [W-1:0] d, input logic p);
`ifdef DESER_PARITY_EN
      return (^d) ^ p;
`else
      return 1'b0 & ((^d) ^ p);
`endif
   endfunction

   // Monitor: a word handshake happens at the next rising edge when these hold.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.m_valid && bus.m_ready && !flush) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_word: got %h expected none", bus.m_data);
         end else begin
            e = sb.pop_front();
            check("word_data", 32'(bus.m_data), 32'(e.data));
            check("word_perr", 32'(bus.m_perr), 32'(e.perr));
         end
      end
   end

   task automatic send_bit(input logic b, input logic rv);
      int t;
      bus.s_valid = 1'b1;
      bus.s_bit   = b;
      bus.reverse = rv;
      t = 0;
      while (!bus.s_ready && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 50) check("s_ready_timeout", 32'(t), 32'd0);
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [W-1:0] stream, input logic rev,
                             input logic toggle, input logic gaps, input logic pbit);
      int g;
      for (int k = 0; k < int'(W); k++) begin
         if (gaps) begin
            g = 0;
            while ($urandom_range(0, 9) >= 3 && g < 6) begin
               bus.s_valid = 1'b0;
               @(posedge clk); #1;
               g++;
            end
         end
         send_bit(stream[k], (k == 0 || !toggle) ? rev : ~bus.reverse);
      end
`ifdef DESER_PARITY_EN
      check("no_valid_before_parity", 32'(bus.m_valid), 32'd0);
      send_bit(pbit, ~rev);
`endif
   endtask

   task automatic push(input logic [W-1:0] d, input logic [W-1:0] stream, input logic p);
      exp_t e;
      e.data = d;
      e.perr = exp_perr(stream, p);
      sb.push_back(e);
   endtask

   initial begin
      logic [W-1:0] s;
      bus.s_valid = 1'b0;
      bus.s_bit   = 1'b0;
      bus.reverse = 1'b0;
      bus.m_ready = 1'b0;

      #2;
      check("rst_m_valid", 32'(bus.m_valid), 32'd0);
      check("rst_m_perr",  32'(bus.m_perr),  32'd0);
      check("rst_busy",    32'(busy),        32'd0);
      check("rst_s_ready", 32'(bus.s_ready), 32'd1);
      check("rst_m_data",  32'(bus.m_data),  32'd0);
      #12 rst_n = 1'b1;
      @(posedge clk); #1;

      // LSB-first single one, consumer always ready.
      bus.m_ready = 1'b1;
      push(23'h000001, 23'h000001, 1'b0);
      send_frame(23'h000001, 1'b0, 1'b0, 1'b0, 1'b0);
      check("lsb_latency_valid", 32'(bus.m_valid), 32'd1);
      check("lsb_busy_in_hold",  32'(busy),        32'd0);
      @(posedge clk); #1;
      check("lsb_valid_one_cycle", 32'(bus.m_valid), 32'd0);
      check("lsb_s_ready_back",    32'(bus.s_ready), 32'd1);

      // MSB-first, reverse toggled after the first bit.
      push(23'h400000, 23'h000001, 1'b0);
      send_frame(23'h000001, 1'b1, 1'b1, 1'b0, 1'b0);
      check("msb_latency_valid", 32'(bus.m_valid), 32'd1);
      @(posedge clk); #1;
      check("msb_valid_one_cycle", 32'(bus.m_valid), 32'd0);

      // Gappy input, consumer stalls ten cycles in HOLD.
      bus.m_ready = 1'b0;
      push(23'h5A5A5A, 23'h5A5A5A, 1'b0);
      send_frame(23'h5A5A5A, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int c = 0; c < 10; c++) begin
         check("hold_s_ready", 32'(bus.s_ready), 32'd0);
         check("hold_m_valid", 32'(bus.m_valid), 32'd1);
         check("hold_m_data",  32'(bus.m_data),  32'h5A5A5A);
         @(posedge clk); #1;
      end
      bus.m_ready = 1'b1;
      @(posedge clk); #1;
      check("hold_release", 32'(bus.m_valid), 32'd0);

      // Flush coincident with the 13th bit handshake.
      s = 23'h0F0F0F;
      for (int k = 0; k < 12; k++) send_bit(s[k], 1'b0);
      bus.s_valid = 1'b1;
      bus.s_bit   = 1'b1;
      flush       = 1'b1;
      @(posedge clk); #1;
      flush       = 1'b0;
      bus.s_valid = 1'b0;
      check("flush_busy",    32'(busy),        32'd0);
      check("flush_m_valid", 32'(bus.m_valid), 32'd0);
      check("flush_s_ready", 32'(bus.s_ready), 32'd1);
      repeat (3) @(posedge clk);
      #1 check("flush_no_word", 32'(bus.m_valid), 32'd0);
      push(23'h7FFFFF, 23'h7FFFFF, 1'b1);
      send_frame(23'h7FFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;

      // Asynchronous reset after seven bits.
      s = 23'h0AAAAA;
      for (int k = 0; k < 7; k++) send_bit(s[k], 1'b1);
      rst_n = 1'b0;
      #1;
      check("arst_m_valid", 32'(bus.m_valid), 32'd0);
      check("arst_busy",    32'(busy),        32'd0);
      check("arst_s_ready", 32'(bus.s_ready), 32'd1);
      check("arst_m_data",  32'(bus.m_data),  32'd0);
      check("arst_m_perr",  32'(bus.m_perr),  32'd0);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      push(23'h123456, 23'h123456, 1'b0);
      send_frame(23'h123456, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;

      // Parity bit 0 then 1 on the same data.
      push(23'h000003, 23'h000003, 1'b0);
      send_frame(23'h000003, 1'b0, 1'b0, 1'b0, 1'b0);
      push(23'h000003, 23'h000003, 1'b1);
      send_frame(23'h000003, 1'b0, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;

      for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
      #1 check("sb_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
